rs_syndrome_calc: RTL

- First stage of the RS(255,n) decoder, directly upstream of the Berlekamp-Massey / GF-multiplier stage.
- Accepts the 255 received symbols of a codeword one per cycle, highest degree first (r254..r0).
- Accumulates 2T syndromes S_j = r(alpha^(FCR+j)) by Horner's rule over GF(2^8), field polynomial x^8+x^4+x^3+x^2+1 (0x11D).
- Double-buffered: the syndromes of codeword k drain to the key-equation solver while codeword k+1 accumulates.

---
 rtl/rs_gf_pkg.sv | 43 ++++
 rtl/gf_const_multiplier.sv | 20 ++
 rtl/rs_syndrome_calc.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rs_gf_pkg.sv
// GF(2^8) helpers for the Reed-Solomon decoder, field polynomial x^8+x^4+x^3+x^2+1.
// Shared types and FSM encodings for the syndrome stage.
package rs_gf_pkg;

    typedef logic [7:0]        gf_elem_t;
    typedef logic [7:0][7:0]   gf_mat_t;
    typedef logic [0:254][7:0] gf_pow_table_t;

    typedef enum logic { IN_ACCUM, IN_HOLD } in_state_e;
    typedef enum logic { OUT_IDLE, OUT_DRAIN } out_state_e;

    localparam gf_elem_t GF_POLY = 8'h1D;

    function automatic gf_elem_t gf_xtime(input gf_elem_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic gf_pow_table_t gf_gen_alpha_pow();
        gf_pow_table_t t;
        gf_elem_t      p;
        p = 8'h01;
        for (int k = 0; k < 255; k++) begin
            t[k] = p;
            p    = gf_xtime(p);
        end
        return t;
    endfunction

    localparam gf_pow_table_t GF_ALPHA_POW = gf_gen_alpha_pow();

    // Row i holds c * x^i, so a product is the XOR of the rows selected by the operand bits.
    function automatic gf_mat_t gf_mul_const(input gf_elem_t c);
        gf_mat_t  m;
        gf_elem_t p;
        p = c;
        for (int i = 0; i < 8; i++) begin
            m[i] = p;
            p    = gf_xtime(p);
        end
        return m;
    endfunction

endpackage

// File: rtl/gf_const_multiplier.sv
// Combinational multiply of a GF(2^8) element by the fixed constant alpha^K.
module gf_const_multiplier
    import rs_gf_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam gf_mat_t M = gf_mul_const(GF_ALPHA_POW[K % 255]);

    always_comb begin
        y = '0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) y = y ^ M[i];
        end
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(255,n) syndrome stage: Horner accumulation of 2T syndromes with a double-buffered
// output bank so one codeword drains while the next accumulates.
module rs_syndrome_calc
    import rs_gf_pkg::*;
#(
    parameter int T   = 8,
    parameter int FCR = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              symbol_in,
    input  logic                    symbol_valid,
    output logic                    symbol_ready,
    output logic [7:0]              syndrome_out,
    output logic [$clog2(2*T)-1:0]  syndrome_index,
    output logic                    syndrome_valid,
    input  logic                    syndrome_ready,
    output logic                    syndromes_done,
    output logic                    error_detected
);

    localparam int NSYN = 2 * T;
    localparam int IDXW = $clog2(NSYN);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSYN - 1);
    localparam logic [7:0]      LAST_SYM = 8'd254;

    logic [7:0]      acc_q [NSYN];
    logic [7:0]      acc_d [NSYN];
    logic [7:0]      bank_q [NSYN];
    logic [7:0]      bank_d [NSYN];
    logic [7:0]      mul [NSYN];
    logic [7:0]      cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            err_q, err_d;
    in_state_e       in_state_q, in_state_d;
    out_state_e      out_state_q, out_state_d;

    logic accept, last_sym, last_xfer, bank_free, load, acc_any;

    for (genvar j = 0; j < NSYN; j++) begin : g_mul
        gf_const_multiplier #(.K(FCR + j)) u_mul (
            .a (acc_q[j]),
            .y (mul[j])
        );
    end

    assign symbol_ready   = (in_state_q == IN_ACCUM);
    assign syndrome_valid = (out_state_q == OUT_DRAIN);
    assign syndrome_out   = bank_q[idx_q];
    assign syndrome_index = idx_q;
    assign syndromes_done = last_xfer;
    assign error_detected = err_q;

    always_comb begin
        accept    = symbol_valid && symbol_ready;
        last_sym  = accept && (cnt_q == LAST_SYM);
        last_xfer = (out_state_q == OUT_DRAIN) && syndrome_ready && (idx_q == LAST_IDX);
        // The bank may be reloaded on the very edge its last syndrome leaves.
        bank_free = (out_state_q == OUT_IDLE) || last_xfer;
        load      = 1'b0;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        in_state_d = in_state_q;

        case (in_state_q)
            IN_ACCUM: begin
                if (accept) begin
                    for (int j = 0; j < NSYN; j++) begin
                        acc_d[j] = ((cnt_q == 8'd0) ? 8'h00 : mul[j]) ^ symbol_in;
                    end
                    cnt_d = last_sym ? 8'd0 : cnt_q + 8'd1;
                    if (last_sym) begin
                        if (bank_free) load = 1'b1;
                        else           in_state_d = IN_HOLD;
                    end
                end
            end
            IN_HOLD: begin
                if (bank_free) begin
                    load       = 1'b1;
                    in_state_d = IN_ACCUM;
                end
            end
            default: in_state_d = IN_ACCUM;
        endcase

        acc_any = 1'b0;
        for (int j = 0; j < NSYN; j++) begin
            acc_any  = acc_any | (|acc_d[j]);
            bank_d[j] = load ? acc_d[j] : bank_q[j];
        end

        idx_d       = idx_q;
        err_d       = err_q;
        out_state_d = out_state_q;
        case (out_state_q)
            OUT_IDLE: begin
                if (load) begin
                    out_state_d = OUT_DRAIN;
                    idx_d       = '0;
                    err_d       = acc_any;
                end
            end
            OUT_DRAIN: begin
                if (syndrome_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d       = '0;
                        out_state_d = load ? OUT_DRAIN : OUT_IDLE;
                        err_d       = load ? acc_any : 1'b0;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < NSYN; j++) begin
                acc_q[j]  <= '0;
                bank_q[j] <= '0;
            end
            cnt_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            in_state_q  <= IN_ACCUM;
            out_state_q <= OUT_IDLE;
        end else begin
            for (int j = 0; j < NSYN; j++) begin
                acc_q[j]  <= acc_d[j];
                bank_q[j] <= bank_d[j];
            end
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
        end
    end

endmodule
